// File: rtl/mul_sched_pkg.sv
// mul_sched_pkg: shared definitions for the shared-multiplier scheduler.
//   WIDTH_LOG / WIDTH / OUT_WIDTH : operand and product widths
//   N_REQ_DEFAULT, CT_LAT_DEFAULT : default requester count and constant-time latency
//   state_e                       : scheduler FSM states
//   cnt_width()                   : width of the latency / drain counters
package mul_sched_pkg;

    localparam int unsigned WIDTH_LOG      = 4;
    localparam int unsigned WIDTH          = 1 << WIDTH_LOG;
    localparam int unsigned OUT_WIDTH      = 2 * WIDTH;
    localparam int unsigned N_REQ_DEFAULT  = 4;
    localparam int unsigned CT_LAT_DEFAULT = WIDTH + 2;

    typedef enum logic [2:0] {
        DRAIN,
        IDLE,
        ISSUE,
        WAIT,
        PAD,
        RESP
    } state_e;

    // One spare bit above what CT_LAT+1 needs so saturation never aliases a valid count.
    function automatic int unsigned cnt_width(int unsigned ct_lat);
        return $clog2(ct_lat + 2) + 1;
    endfunction

endpackage

// File: rtl/mul_sched_if.sv
// mul_sched_if: bundles the requester, response and MUL-side signals of mul_sched.
//   req_valid/req_ready/req_a/req_b/ct_mode : requester side (packed, slice i = requester i)
//   resp_valid/resp_ready/resp_o/resp_id    : response side
//   mul_in_valid/mul_stall/mul_a/mul_b      : scheduler -> MUL
//   mul_o/mul_out_valid                     : MUL -> scheduler
//   sched_busy/ct_overrun                   : status
// Modport slave is the scheduler's view, master is the environment's view.
interface mul_sched_if #(
    parameter int unsigned N_REQ = mul_sched_pkg::N_REQ_DEFAULT
) ();
    import mul_sched_pkg::*;

    localparam int unsigned ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic                   ct_mode;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [OUT_WIDTH-1:0]   resp_o;
    logic [ID_W-1:0]        resp_id;
    logic                   mul_in_valid;
    logic                   mul_stall;
    logic [WIDTH-1:0]       mul_a;
    logic [WIDTH-1:0]       mul_b;
    logic [OUT_WIDTH-1:0]   mul_o;
    logic                   mul_out_valid;
    logic                   sched_busy;
    logic                   ct_overrun;

    modport slave (
        input  req_valid, req_a, req_b, ct_mode, resp_ready, mul_o, mul_out_valid,
        output req_ready, resp_valid, resp_o, resp_id, mul_in_valid, mul_stall,
        output mul_a, mul_b, sched_busy, ct_overrun
    );

    modport master (
        output req_valid, req_a, req_b, ct_mode, resp_ready, mul_o, mul_out_valid,
        input  req_ready, resp_valid, resp_o, resp_id, mul_in_valid, mul_stall,
        input  mul_a, mul_b, sched_busy, ct_overrun
    );

endinterface

// File: rtl/mul_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req     in  N_REQ : request vector
//   last    in  ID_W  : index granted last time; search starts just after it (wrapping)
//   gnt     out N_REQ : one-hot grant
//   gnt_idx out ID_W  : index of the granted requester
//   gnt_any out 1     : some request was granted
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_idx,
    output logic             gnt_any
);

    int unsigned     cand;
    logic [ID_W-1:0] cand_idx;
    logic            found;

    always_comb begin
        gnt      = '0;
        gnt_idx  = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            cand     = (32'(last) + off) % N_REQ;
            cand_idx = ID_W'(cand);
            if (!found && req[cand_idx]) begin
                found         = 1'b1;
                gnt[cand_idx] = 1'b1;
                gnt_idx       = cand_idx;
            end
        end
    end

    assign gnt_any = found;

endmodule

// File: rtl/mul_sched.sv
// mul_sched: time-shares one shift-and-add MUL unit among N_REQ requesters.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mul_sched_if.slave (requests, response, MUL drive/return, status)
// One operation in flight, round-robin grant, registered response held until resp_ready.
// In constant-time mode the response is padded to CT_LAT cycles after issue so operand-
// dependent MUL early termination is not observable.
module mul_sched
    import mul_sched_pkg::*;
#(
    parameter int unsigned N_REQ  = N_REQ_DEFAULT,
    parameter int unsigned CT_LAT = CT_LAT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    mul_sched_if.slave bus
);

    localparam int unsigned   ID_W       = $clog2(N_REQ);
    localparam int unsigned   CW         = cnt_width(CT_LAT);
    localparam logic [CW-1:0] CT_LAT_C   = CW'(CT_LAT);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(CT_LAT + 1);

    state_e               state_q, state_d;
    logic [CW-1:0]        lat_q, lat_d, lat_inc;
    logic [CW-1:0]        cnt_q, cnt_d, cnt_inc;
    logic [ID_W-1:0]      rr_q, id_q, gnt_idx;
    logic [N_REQ-1:0]     gnt;
    logic                 gnt_any;
    logic [WIDTH-1:0]     a_q, b_q;
    logic                 ct_q, ovr_q, mov_q;
    logic [OUT_WIDTH-1:0] res_q;
    logic                 grab, capture, set_ovr, first_valid;
    logic [WIDTH-1:0]     opa [N_REQ];
    logic [WIDTH-1:0]     opb [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign opa[i] = bus.req_a[i*WIDTH +: WIDTH];
        assign opb[i] = bus.req_b[i*WIDTH +: WIDTH];
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req     (bus.req_valid),
        .last    (rr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // MUL may hold out_valid for two cycles; only the rising cycle carries a new result.
    assign first_valid = bus.mul_out_valid & ~mov_q;

    // lat_inc is the number of cycles elapsed since the ISSUE cycle.
    assign lat_inc = (&lat_q) ? lat_q : lat_q + CW'(1);
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d          = state_q;
        lat_d            = lat_q;
        cnt_d            = cnt_q;
        grab             = 1'b0;
        capture          = 1'b0;
        set_ovr          = 1'b0;
        bus.req_ready    = '0;
        bus.mul_in_valid = 1'b0;
        bus.mul_a        = '0;
        bus.mul_b        = '0;
        bus.resp_valid   = 1'b0;

        unique case (state_q)
            DRAIN: begin
                // MUL has no reset: wait out any operation it may still be running.
                cnt_d = cnt_inc;
                if (cnt_q >= DRAIN_LAST && !bus.mul_out_valid) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (gnt_any && !bus.mul_out_valid) begin
                    bus.req_ready = gnt;
                    grab          = 1'b1;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                bus.mul_in_valid = 1'b1;
                bus.mul_a        = a_q;
                bus.mul_b        = b_q;
                lat_d            = '0;
                state_d          = WAIT;
            end
            WAIT: begin
                lat_d = lat_inc;
                if (first_valid) begin
                    capture = 1'b1;
                    if (!ct_q || lat_inc >= CT_LAT_C) begin
                        state_d = RESP;
                        set_ovr = ct_q && (lat_inc > CT_LAT_C);
                    end else begin
                        state_d = PAD;
                    end
                end
            end
            PAD: begin
                lat_d = lat_inc;
                if (lat_inc >= CT_LAT_C) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = DRAIN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DRAIN;
            lat_q   <= '0;
            cnt_q   <= '0;
            rr_q    <= ID_W'(N_REQ - 1);
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ct_q    <= 1'b0;
            res_q   <= '0;
            ovr_q   <= 1'b0;
            mov_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            cnt_q   <= cnt_d;
            mov_q   <= bus.mul_out_valid;
            if (grab) begin
                a_q  <= opa[gnt_idx];
                b_q  <= opb[gnt_idx];
                id_q <= gnt_idx;
                ct_q <= bus.ct_mode;
                rr_q <= gnt_idx;
            end
            if (capture) begin
                res_q <= bus.mul_o;
            end
            if (set_ovr) begin
                ovr_q <= 1'b1;
            end
        end
    end

    assign bus.resp_o     = res_q;
    assign bus.resp_id    = id_q;
    assign bus.mul_stall  = 1'b0;
    assign bus.sched_busy = (state_q != IDLE);
    assign bus.ct_overrun = ovr_q;

endmodule

// File: tb/tb_mul_sched.sv
// tb_mul_sched: self-checking bench for mul_sched with a behavioural MUL unit attached.
// Expected grants, products and response latencies come from a reference model that
// applies the round-robin rule and the latency formulas directly.
module tb_mul_sched;
    import mul_sched_pkg::*;

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned CT_LAT = WIDTH + 2;
    localparam int unsigned ID_W   = $clog2(N_REQ);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mul_sched_if #(.N_REQ(N_REQ)) ifc ();

    mul_sched #(
        .N_REQ  (N_REQ),
        .CT_LAT (CT_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rr_last = N_REQ - 1;

    // ---------------- behavioural MUL unit (no reset, early termination) ----------------
    logic [OUT_WIDTH-1:0] m_prod   = '0;
    int                   m_left   = 0;
    bit                   m_second = 1'b0;

    function automatic int msb(logic [WIDTH-1:0] v);
        int m = 0;
        for (int i = 0; i < int'(WIDTH); i++) if (v[i]) m = i;
        return m;
    endfunction

    // Cycles from in_valid to the first out_valid cycle.
    function automatic int mul_lat(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
        if (a == '0 || b == '0) return 2;
        return msb(b) + 3;
    endfunction

    always @(posedge clk) begin
        if (ifc.mul_in_valid) begin
            m_prod            <= OUT_WIDTH'(ifc.mul_a) * OUT_WIDTH'(ifc.mul_b);
            m_left            <= mul_lat(ifc.mul_a, ifc.mul_b) - 1;
            m_second          <= 1'b0;
            ifc.mul_out_valid <= 1'b0;
        end else if (m_left > 1) begin
            m_left            <= m_left - 1;
            ifc.mul_out_valid <= 1'b0;
        end else if (m_left == 1) begin
            m_left            <= 0;
            ifc.mul_out_valid <= 1'b1;
            ifc.mul_o         <= m_prod;
            m_second          <= 1'b1;
        end else if (m_second) begin
            m_second          <= 1'b0;
        end else begin
            ifc.mul_out_valid <= 1'b0;
        end
    end

    // ---------------- reference model helpers ----------------
    function automatic int pick(logic [N_REQ-1:0] mask, int last);
        for (int off = 1; off <= int'(N_REQ); off++) begin
            int c;
            c = (last + off) % int'(N_REQ);
            if (mask[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [WIDTH-1:0] rand_opnd();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            default: return WIDTH'($urandom);
        endcase
    endfunction

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Full transaction: request, grant, issue, response (optionally held off for `hold` cycles).
    task automatic run_op(input logic [N_REQ-1:0] mask, input logic [N_REQ*WIDTH-1:0] pa,
                          input logic [N_REQ*WIDTH-1:0] pb, input bit ct, input int hold);
        int exp_g, t0, exp_lat, pulses, waited;
        bit stray;
        logic [WIDTH-1:0]     a, b;
        logic [OUT_WIDTH-1:0] r_o;
        logic [ID_W-1:0]      r_id;
        ifc.req_valid  = mask;
        ifc.req_a      = pa;
        ifc.req_b      = pb;
        ifc.ct_mode    = ct;
        ifc.resp_ready = (hold == 0);
        #1;
        waited = 0;
        while (ifc.req_ready == '0 && waited < 100) begin
            step(); #1;
            waited++;
        end
        exp_g = pick(mask, rr_last);
        check("grant", 64'(ifc.req_ready), 64'(1) << exp_g);
        rr_last = exp_g;
        a = pa[exp_g*WIDTH +: WIDTH];
        b = pb[exp_g*WIDTH +: WIDTH];
        step();
        ifc.req_valid = '0;
        #1;
        check("issue_valid", 64'(ifc.mul_in_valid), 64'(1));
        check("issue_ab", 64'({ifc.mul_a, ifc.mul_b}), 64'({a, b}));
        t0 = cyc; pulses = 1; stray = 1'b0; waited = 0;
        while (!ifc.resp_valid && waited < 100) begin
            step(); #1;
            waited++;
            if (ifc.mul_in_valid) pulses++;
            if (ifc.req_ready != '0) stray = 1'b1;
        end
        exp_lat = ct ? int'(CT_LAT) + 1 : (a == '0 || b == '0) ? 3 : msb(b) + 4;
        check("latency", 64'(cyc - t0), 64'(exp_lat));
        check("product", 64'(ifc.resp_o), 64'(a) * 64'(b));
        check("resp_id", 64'(ifc.resp_id), 64'(exp_g));
        check("one_issue", 64'(pulses), 64'(1));
        check("no_grant_in_flight", 64'(stray), 64'(0));
        r_o  = ifc.resp_o;
        r_id = ifc.resp_id;
        if (hold > 0) begin
            ifc.req_valid = mask;
            for (int i = 0; i < hold; i++) begin
                step(); #1;
                check("stall_valid", 64'(ifc.resp_valid), 64'(1));
                check("stall_o", 64'(ifc.resp_o), 64'(r_o));
                check("stall_id", 64'(ifc.resp_id), 64'(r_id));
                check("stall_no_ready", 64'(ifc.req_ready), 64'(0));
                check("stall_no_issue", 64'(ifc.mul_in_valid), 64'(0));
            end
            ifc.req_valid  = '0;
            ifc.resp_ready = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            check("no_dup_resp", 64'(ifc.resp_valid), 64'(0));
        end
    endtask

    // ---------------- directed + random sequence ----------------
    logic [N_REQ*WIDTH-1:0] pa, pb;
    int  count;
    bit  stray;

    initial begin
        ifc.req_valid  = '0;
        ifc.req_a      = '0;
        ifc.req_b      = '0;
        ifc.ct_mode    = 1'b0;
        ifc.resp_ready = 1'b1;
        rst            = 1'b1;
        repeat (3) step();
        #1;
        check("rst_req_ready", 64'(ifc.req_ready), 64'(0));
        check("rst_resp_valid", 64'(ifc.resp_valid), 64'(0));
        check("rst_resp_o", 64'(ifc.resp_o), 64'(0));
        check("rst_resp_id", 64'(ifc.resp_id), 64'(0));
        check("rst_mul_in_valid", 64'(ifc.mul_in_valid), 64'(0));
        check("rst_mul_stall", 64'(ifc.mul_stall), 64'(0));
        check("rst_mul_ab", 64'({ifc.mul_a, ifc.mul_b}), 64'(0));
        check("rst_ct_overrun", 64'(ifc.ct_overrun), 64'(0));

        // Drain after reset with a quiet MUL lasts exactly CT_LAT+2 cycles.
        rst   = 1'b0;
        count = 0;
        while (ifc.sched_busy && count < 200) begin
            step(); #1;
            count++;
        end
        check("drain_len", 64'(count), 64'(CT_LAT + 2));

        // a=3, b=5 plain, then constant-time, then full-scale constant-time.
        pa = '0; pb = '0;
        pa[0 +: WIDTH] = WIDTH'(3);
        pb[0 +: WIDTH] = WIDTH'(5);
        run_op(4'b0001, pa, pb, 1'b0, 0);
        run_op(4'b0001, pa, pb, 1'b1, 0);
        pa[0 +: WIDTH] = '1;
        pb[0 +: WIDTH] = '1;
        run_op(4'b0001, pa, pb, 1'b1, 0);

        // Zero operand: early termination, second out_valid cycle must not duplicate.
        pa[0 +: WIDTH] = WIDTH'(7);
        pb[0 +: WIDTH] = '0;
        run_op(4'b0001, pa, pb, 1'b0, 0);

        // Move the pointer to requester 3, then all four contend: order 0,1,2,3,0.
        for (int i = 0; i < int'(N_REQ); i++) begin
            pa[i*WIDTH +: WIDTH] = WIDTH'($urandom);
            pb[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
        run_op(4'b1000, pa, pb, 1'b1, 0);
        for (int i = 0; i < 5; i++) run_op(4'b1111, pa, pb, 1'b0, 0);

        // Backpressure: response held 10 cycles while another requester waits.
        run_op(4'b0110, pa, pb, 1'b0, 10);

        // Randomized traffic.
        for (int it = 0; it < 12; it++) begin
            logic [N_REQ-1:0] m;
            m = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
            for (int i = 0; i < int'(N_REQ); i++) begin
                pa[i*WIDTH +: WIDTH] = rand_opnd();
                pb[i*WIDTH +: WIDTH] = rand_opnd();
            end
            run_op(m, pa, pb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        // Reset during WAIT on a long op: result dropped, drain, then a fresh op.
        pa = '0; pb = '0;
        pa[2*WIDTH +: WIDTH] = '1;
        pb[2*WIDTH +: WIDTH] = WIDTH'(16'h8000);
        ifc.req_valid  = 4'b0100;
        ifc.req_a      = pa;
        ifc.req_b      = pb;
        ifc.ct_mode    = 1'b0;
        ifc.resp_ready = 1'b1;
        #1;
        count = 0;
        while (ifc.req_ready == '0 && count < 100) begin
            step(); #1;
            count++;
        end
        check("rst_test_grant", 64'(ifc.req_ready), 64'(4'b0100));
        step();
        ifc.req_valid = '0;
        repeat (5) step();
        #1;
        check("rst_test_waiting", 64'(ifc.resp_valid), 64'(0));
        rst = 1'b1;
        pa[0 +: WIDTH] = WIDTH'(2);
        pb[0 +: WIDTH] = WIDTH'(3);
        ifc.req_a     = pa;
        ifc.req_b     = pb;
        ifc.req_valid = 4'b0001;
        step(); #1;
        rst     = 1'b0;
        rr_last = N_REQ - 1;
        count   = 0;
        stray   = 1'b0;
        while (ifc.sched_busy && count < 200) begin
            if (ifc.req_ready != '0 || ifc.resp_valid) stray = 1'b1;
            step(); #1;
            count++;
        end
        check("rst_drain_min", 64'(count >= int'(CT_LAT) + 2), 64'(1));
        check("rst_no_leak", 64'(stray), 64'(0));
        run_op(4'b0001, pa, pb, 1'b0, 0);

        check("ct_overrun_clear", 64'(ifc.ct_overrun), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
